// File: rtl/l2_fetch_arbiter.sv
// Round-robin arbiter sharing one L2 fetch port between icache and dcache.
// One transaction in flight; IDLE -> WAIT (memReq held) -> RESPOND bubble -> IDLE.
module l2_fetch_arbiter #(
  parameter int PHYSICAL_ADDRESS_LENGTH = 56,
  parameter int CACHELINESIZE           = 64,
  parameter int CNTWIDTH                = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               icReq,
  input  logic [PHYSICAL_ADDRESS_LENGTH-1:0] icAddress,
  output logic                               icDone,
  output logic [CACHELINESIZE-1:0]           icData,
  input  logic                               dcReq,
  input  logic [PHYSICAL_ADDRESS_LENGTH-1:0] dcAddress,
  output logic                               dcDone,
  output logic [CACHELINESIZE-1:0]           dcData,
  output logic                               memReq,
  output logic [PHYSICAL_ADDRESS_LENGTH-1:0] memAddress,
  input  logic                               memDone,
  input  logic [CACHELINESIZE-1:0]           memData,
  output logic                               owner,
  output logic [CNTWIDTH-1:0]                icGrants,
  output logic [CNTWIDTH-1:0]                dcGrants
);

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_e;

  localparam logic [CNTWIDTH-1:0] CNT_MAX = '1;

  state_e                             state_q, state_d;
  logic                               memReq_q, memReq_d;
  logic [PHYSICAL_ADDRESS_LENGTH-1:0] memAddress_q, memAddress_d;
  logic                               owner_q, owner_d;
  logic                               icDone_q, icDone_d, dcDone_q, dcDone_d;
  logic [CACHELINESIZE-1:0]           icData_q, icData_d, dcData_q, dcData_d;
  logic [CNTWIDTH-1:0]                icGrants_q, icGrants_d, dcGrants_q, dcGrants_d;
  logic                               grant_dc;

  // On a tie the previous grantee loses; a lone requester always wins.
  assign grant_dc = dcReq & (~icReq | ~owner_q);

  always_comb begin
    state_d      = state_q;
    memReq_d     = memReq_q;
    memAddress_d = memAddress_q;
    owner_d      = owner_q;
    icDone_d     = 1'b0;
    dcDone_d     = 1'b0;
    icData_d     = icData_q;
    dcData_d     = dcData_q;
    icGrants_d   = icGrants_q;
    dcGrants_d   = dcGrants_q;
    case (state_q)
      IDLE: begin
        if (icReq | dcReq) begin
          owner_d      = grant_dc;
          memAddress_d = grant_dc ? dcAddress : icAddress;
          memReq_d     = 1'b1;
          state_d      = WAIT;
          if (grant_dc) begin
            if (dcGrants_q != CNT_MAX) dcGrants_d = dcGrants_q + CNTWIDTH'(1);
          end else begin
            if (icGrants_q != CNT_MAX) icGrants_d = icGrants_q + CNTWIDTH'(1);
          end
        end
      end
      WAIT: begin
        if (memDone) begin
          memReq_d = 1'b0;
          state_d  = RESPOND;
          if (owner_q) begin
            dcData_d = memData;
            dcDone_d = 1'b1;
          end else begin
            icData_d = memData;
            icDone_d = 1'b1;
          end
        end
      end
      // Gives the requester a cycle to drop its level request after Done.
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      memReq_q     <= 1'b0;
      memAddress_q <= '0;
      owner_q      <= 1'b1;
      icDone_q     <= 1'b0;
      dcDone_q     <= 1'b0;
      icData_q     <= '0;
      dcData_q     <= '0;
      icGrants_q   <= '0;
      dcGrants_q   <= '0;
    end else begin
      state_q      <= state_d;
      memReq_q     <= memReq_d;
      memAddress_q <= memAddress_d;
      owner_q      <= owner_d;
      icDone_q     <= icDone_d;
      dcDone_q     <= dcDone_d;
      icData_q     <= icData_d;
      dcData_q     <= dcData_d;
      icGrants_q   <= icGrants_d;
      dcGrants_q   <= dcGrants_d;
    end
  end

  assign memReq     = memReq_q;
  assign memAddress = memAddress_q;
  assign owner      = owner_q;
  assign icDone     = icDone_q;
  assign dcDone     = dcDone_q;
  assign icData     = icData_q;
  assign dcData     = dcData_q;
  assign icGrants   = icGrants_q;
  assign dcGrants   = dcGrants_q;

endmodule
